axi_read_master: RTL and testbench

AXI_READ_MASTER -- requirements
Module: axi_read_master

---
 rtl/axi_read_master.sv | 123 ++++++++++++
 tb/tb_axi_read_master.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_master.sv
// AXI4 read master: issues one INCR burst per command and forwards the R beats downstream.
// Latency: AR is presented the cycle after the command is accepted; each R beat appears on out_* one cycle after its handshake.
// Backpressure: a single-entry output register; rready drops while a beat is held and out_ready is low.
//
// Ports:
//   aclk, aresetn                    clock, async active-low reset
//   cmd_valid/cmd_ready/addr/len     burst request (len uses arlen encoding: beats-1)
//   ar*                              AXI read-address channel
//   r*                               AXI read-data channel
//   out_data/out_last/valid/ready    forwarded beats
//   done/done_err                    one-cycle completion pulse and burst error status
module axi_read_master #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
   input  logic [7:0]               cmd_len,
   output logic [ADDRESS_WIDTH-1:0] araddr,
   output logic [7:0]               arlen,
   output logic [2:0]               arsize,
   output logic [1:0]               arburst,
   output logic                     arvalid,
   input  logic                     arready,
   input  logic [DATA_WIDTH-1:0]    rdata,
   input  logic [1:0]               rresp,
   input  logic                     rlast,
   input  logic                     rvalid,
   output logic                     rready,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic                     out_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     done,
   output logic                     done_err
);

   localparam logic [2:0] ARSIZE = 3'($clog2(DATA_WIDTH / 8));

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t     state;
   logic [7:0] beat_cnt;
   logic       err_flag;
   logic       r_hs;
   logic       last_beat;
   logic       beat_err;

   assign cmd_ready = (state == IDLE);
   assign arvalid   = (state == ADDR);
   assign arsize    = ARSIZE;

   // Accept a new beat only when the output register is empty or draining this cycle.
   assign rready    = (state == DATA) && (!out_valid || out_ready);
   assign r_hs      = rvalid && rready;

   // The burst is terminated by our own count; rlast is only cross-checked.
   assign last_beat = (beat_cnt == arlen);
   assign beat_err  = (rresp != 2'b00) || (rlast != last_beat);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state     <= IDLE;
         beat_cnt  <= 8'd0;
         err_flag  <= 1'b0;
         araddr    <= '0;
         arlen     <= 8'd0;
         arburst   <= 2'b01;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_valid <= 1'b0;
         done      <= 1'b0;
         done_err  <= 1'b0;
      end else begin
         done     <= 1'b0;
         done_err <= 1'b0;
         arburst  <= 2'b01;

         // Output register: a new beat overrides the drain so back-to-back beats keep out_valid high.
         if (r_hs) begin
            out_data  <= rdata;
            out_last  <= last_beat;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  araddr <= cmd_addr;
                  arlen  <= cmd_len;
                  state  <= ADDR;
               end
            end
            ADDR: begin
               if (arready) begin
                  beat_cnt <= 8'd0;
                  state    <= DATA;
               end
            end
            DATA: begin
               if (r_hs) begin
                  beat_cnt <= 8'(beat_cnt + 8'd1);
                  if (last_beat) begin
                     state    <= IDLE;
                     done     <= 1'b1;
                     done_err <= err_flag || beat_err;
                     err_flag <= 1'b0;
                  end else if (beat_err) begin
                     err_flag <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_read_master.sv
// Testbench for axi_read_master: directed bursts followed by randomized bursts.
// Latency: n/a.
// Backpressure: out_ready held high, toggled, or randomized per burst.
module tb_axi_read_master;

   logic        aclk;
   logic        aresetn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_addr;
   logic [7:0]  cmd_len;
   logic [7:0]  araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic [31:0] out_data;
   logic        out_last;
   logic        out_valid;
   logic        out_ready;
   logic        done;
   logic        done_err;

   axi_read_master #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
      .done(done), .done_err(done_err)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] d;
      logic        l;
   } beat_t;

   localparam int P_IDLE = 0;
   localparam int P_ADDR = 1;
   localparam int P_DATA = 2;

   beat_t      q[$];          // beats captured but not yet taken downstream
   int         m_phase = P_IDLE;
   logic [7:0] m_addr, m_len;
   int         m_beat;
   bit         m_err;
   bit         exp_done = 0;
   bit         exp_err  = 0;
   int         bursts_done = 0;

   always @(negedge aclk) begin
      if (!aresetn) begin
         chk("rst_cmd_ready", cmd_ready, 1);
         chk("rst_arvalid",   arvalid,   0);
         chk("rst_rready",    rready,    0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_out_last",  out_last,  0);
         chk("rst_done",      done,      0);
         chk("rst_done_err",  done_err,  0);
         chk("rst_araddr",    araddr,    0);
         chk("rst_arlen",     arlen,     0);
         chk("rst_arburst",   arburst,   1);
         chk("rst_out_data",  out_data,  0);
         m_phase  = P_IDLE;
         q.delete();
         exp_done = 0;
         m_err    = 0;
      end else begin
         bit exp_rready;
         chk("cmd_ready", cmd_ready, m_phase == P_IDLE);
         chk("arvalid",   arvalid,   m_phase == P_ADDR);
         chk("arsize",    arsize,    3'd2);
         if (m_phase == P_ADDR) begin
            chk("araddr",  araddr,  m_addr);
            chk("arlen",   arlen,   m_len);
            chk("arburst", arburst, 2'b01);
         end
         chk("done", done, exp_done);
         if (exp_done) chk("done_err", done_err, exp_err);
         exp_done = 0;

         chk("out_valid", out_valid, q.size() != 0);
         if (q.size() != 0) begin
            chk("out_data", out_data, q[0].d);
            chk("out_last", out_last, q[0].l);
         end
         exp_rready = (m_phase == P_DATA) && (q.size() == 0 || out_ready);
         chk("rready", rready, exp_rready);

         // Transfers that happen at the coming rising edge.
         if (q.size() != 0 && out_ready) void'(q.pop_front());
         case (m_phase)
            P_IDLE: if (cmd_valid) begin
               m_addr  = cmd_addr;
               m_len   = cmd_len;
               m_phase = P_ADDR;
            end
            P_ADDR: if (arready) begin
               m_phase = P_DATA;
               m_beat  = 0;
            end
            default: if (exp_rready && rvalid) begin
               bit is_last;
               beat_t b;
               is_last = (m_beat == int'(m_len));
               b.d = rdata;
               b.l = is_last;
               q.push_back(b);
               if (rresp != 2'b00 || rlast != is_last) m_err = 1;
               if (is_last) begin
                  exp_done = 1;
                  exp_err  = m_err;
                  m_err    = 0;
                  m_phase  = P_IDLE;
                  bursts_done++;
               end else begin
                  m_beat++;
               end
            end
         endcase
      end
   end

   // ---------------- stimulus ----------------
   // oready_mode: 0 always ready, 1 toggle each cycle, 2 random.
   // busy: randomize arready/rvalid instead of holding them high.
   task automatic drive_cycle(input int idx, input int len, input int bad_beat, input int last_at,
                              input int oready_mode, input bit busy, inout bit tog);
      arready = busy ? 1'($urandom_range(0, 1)) : 1'b1;
      rvalid  = busy ? ($urandom_range(0, 9) < 7) : 1'b1;
      rdata   = $urandom;
      rresp   = (idx == bad_beat) ? 2'b10 : 2'b00;
      rlast   = (idx <= len) ? (idx == last_at) : 1'($urandom_range(0, 1));
      tog     = ~tog;
      case (oready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = tog;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic run_burst(input logic [7:0] addr, input int len, input int bad_beat,
                            input int last_at, input int oready_mode, input bit busy,
                            input int rst_beat);
      int idx = 0;
      bit cmd_hs;
      bit aborted = 0;
      bit tog = 1'b0;
      cmd_valid = 1'b1;
      cmd_addr  = addr;
      cmd_len   = 8'(len);
      for (int cyc = 0; cyc < 600 && idx <= len && !aborted; cyc++) begin
         @(negedge aclk);
         cmd_hs = cmd_valid && cmd_ready;
         if (rvalid && rready) idx++;
         @(posedge aclk);
         #1;
         if (cmd_hs) cmd_valid = 1'b0;
         if (rst_beat >= 0 && idx == rst_beat) begin
            aresetn   = 1'b0;
            cmd_valid = 1'b0;
            repeat (3) @(posedge aclk);
            #1 aresetn = 1'b1;
            aborted = 1;
         end else begin
            drive_cycle(idx, len, bad_beat, last_at, oready_mode, busy, tog);
         end
      end
      if (!aborted) chk("burst_timeout", idx > len, 1);
   endtask

   initial begin
      aresetn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_addr  = 8'd0;
      cmd_len   = 8'd0;
      arready   = 1'b0;
      rdata     = 32'd0;
      rresp     = 2'b00;
      rlast     = 1'b0;
      rvalid    = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge aclk);
      #1 aresetn = 1'b1;

      // Stray R traffic while idle must be ignored.
      repeat (3) begin
         @(posedge aclk);
         #1 rvalid = 1'b1;
         rdata = $urandom;
      end

      run_burst(8'h10, 5, -1, 5, 0, 1'b0, -1);  // straight burst
      run_burst(8'h20, 0, -1, 0, 0, 1'b0, -1);  // single beat
      run_burst(8'h30, 3, -1, 3, 1, 1'b0, -1);  // toggling out_ready
      run_burst(8'h40, 3,  1, 3, 0, 1'b0, -1);  // SLVERR on beat 1
      run_burst(8'h50, 3, -1, 3, 0, 1'b0, -1);  // clean after error
      run_burst(8'h60, 3, -1, 2, 0, 1'b0, -1);  // early rlast
      run_burst(8'h70, 5, -1, 5, 0, 1'b0,  2);  // reset mid-burst
      run_burst(8'h80, 5, -1, 5, 0, 1'b0, -1);  // clean after reset

      for (int n = 0; n < 25; n++) begin
         int len = $urandom_range(0, 12);
         int bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
         int la  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len + 1) : len;
         run_burst(8'($urandom), len, bad, la, $urandom_range(0, 2), 1'b1, -1);
      end

      out_ready = 1'b1;
      rvalid    = 1'b0;
      repeat (5) @(posedge aclk);
      @(negedge aclk);
      chk("drained", q.size(), 0);
      chk("bursts_done", bursts_done, 32);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
